// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// latched operation encoding and the port index constants that identify
// the instruction-fetch port (0) and the load/store port (1).
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

endpackage

// File: rtl/ram_arb_select.sv
// ---------------------------------------------------------------------------
// ram_arb_select
// Combinational 2-way picker deciding which requesting port is served next.
// Build option: define RAM_ARB_RR_EN for round-robin arbitration (on a tie
// the port that was not granted last wins); otherwise fixed priority with
// the load/store port (p1) above the fetch port (p0).
//
// Ports:
//   req[1:0]    in   request vector, bit 0 = p0, bit 1 = p1
//   last_grant  in   port granted by the previous transaction
//   grant       out  selected port (meaningful only when req != 0)
// ---------------------------------------------------------------------------
module ram_arb_select
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

`ifdef RAM_ARB_RR_EN
    // A tie goes to the port that did not win last time; a lone requester
    // always wins.
    always_comb begin
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[0] ? PORT_FETCH : PORT_LSU;
        end
    end
`else
    // p0 only wins when it is the sole requester.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = (req[1] || !req[0]) ? PORT_LSU : PORT_FETCH;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single SRAM wrapper between the instruction-fetch port (p0)
// and the load/store port (p1). One transaction is captured in IDLE,
// strobed to the RAM for exactly one cycle in ISSUE, and completed in WAIT
// when the RAM answers; the granted port then sees a one-cycle ready pulse.
// Build option: RAM_ARB_RR_EN selects round-robin arbitration (see
// ram_arb_select); the default is fixed priority p1 > p0.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   pN_read_i/pN_write_i      held requests from port N (write wins if both)
//   pN_addr_i/data_i/byte_select_i   request payload
//   pN_ready_o                completion pulse, pN_data_o read data
//   ram_read_o/ram_write_o    one-cycle RAM strobes
//   ram_addr_o/data_o/byte_select_o  registered RAM payload
//   ram_ready_i/ram_data_i    RAM completion and read data
//   grant_o                   current/last granted port, busy_o in ISSUE/WAIT
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p0_read_i,
    input  logic                  p0_write_i,
    input  logic [ADDR_W-1:0]     p0_addr_i,
    input  logic [DATA_W-1:0]     p0_data_i,
    input  logic [DATA_W/8-1:0]   p0_byte_select_i,
    output logic                  p0_ready_o,
    output logic [DATA_W-1:0]     p0_data_o,
    input  logic                  p1_read_i,
    input  logic                  p1_write_i,
    input  logic [ADDR_W-1:0]     p1_addr_i,
    input  logic [DATA_W-1:0]     p1_data_i,
    input  logic [DATA_W/8-1:0]   p1_byte_select_i,
    output logic                  p1_ready_o,
    output logic [DATA_W-1:0]     p1_data_o,
    output logic                  ram_read_o,
    output logic                  ram_write_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_data_o,
    output logic [DATA_W/8-1:0]   ram_byte_select_o,
    input  logic                  ram_ready_i,
    input  logic [DATA_W-1:0]     ram_data_i,
    output logic                  grant_o,
    output logic                  busy_o
);

    localparam int BS_W = DATA_W / 8;

    state_t            state;
    logic [1:0]        req;
    logic              sel;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [BS_W-1:0]   sel_bs;
    op_t               next_op;

    assign req = {p1_read_i | p1_write_i, p0_read_i | p0_write_i};

    ram_arb_select u_select (
        .req        (req),
        .last_grant (grant_o),
        .grant      (sel)
    );

    // Payload of whichever port the picker chose this cycle.
    always_comb begin
        if (sel == PORT_LSU) begin
            sel_write = p1_write_i;
            sel_addr  = p1_addr_i;
            sel_data  = p1_data_i;
            sel_bs    = p1_byte_select_i;
        end else begin
            sel_write = p0_write_i;
            sel_addr  = p0_addr_i;
            sel_data  = p0_data_i;
            sel_bs    = p0_byte_select_i;
        end
    end

    // A port raising both read and write is treated as a write.
    assign next_op = sel_write ? OP_WRITE : OP_READ;

    // Transaction FSM. The strobes are loaded on the IDLE->ISSUE edge so
    // they are high for exactly the ISSUE cycle, and cleared leaving it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            ram_read_o        <= 1'b0;
            ram_write_o       <= 1'b0;
            ram_addr_o        <= '0;
            ram_data_o        <= '0;
            ram_byte_select_o <= '0;
            grant_o           <= PORT_FETCH;
            busy_o            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        ram_addr_o        <= sel_addr;
                        ram_data_o        <= sel_data;
                        ram_byte_select_o <= sel_bs;
                        ram_write_o       <= (next_op == OP_WRITE);
                        ram_read_o        <= (next_op == OP_READ);
                        grant_o           <= sel;
                        busy_o            <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_read_o  <= 1'b0;
                    ram_write_o <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (ram_ready_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion is forwarded in the same cycle the RAM answers; answers
    // outside WAIT (e.g. after a reset abort) never reach a port.
    assign p0_ready_o = (state == WAIT) && ram_ready_i && (grant_o == PORT_FETCH);
    assign p1_ready_o = (state == WAIT) && ram_ready_i && (grant_o == PORT_LSU);

    assign p0_data_o = ram_data_i;
    assign p1_data_o = ram_data_i;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-port arbiter that shares the single on-chip SRAM wrapper between the instruction-fetch port (p0) and the load/store port (p1). It captures one requester's transaction, issues it to the RAM for exactly one cycle, waits for the RAM ready, then returns the ready and read data to the granted requester. It sits between the core's memory ports and the RAM wrapper.

Parameters:
ADDR_W, 15, word address width driven to the RAM
DATA_W, 32, data width; byte-select width is DATA_W/8

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
p0_read_i  in  1  fetch port read request, held until p0_ready_o
p0_write_i  in  1  fetch port write request, held until p0_ready_o
p0_addr_i  in  ADDR_W  fetch port address
p0_data_i  in  DATA_W  fetch port write data
p0_byte_select_i  in  DATA_W/8  fetch port byte write mask
p0_ready_o  out  1  one-cycle completion pulse to p0
p0_data_o  out  DATA_W  read data to p0, valid only with p0_ready_o
p1_*  (same seven signals as p0) for the load/store port
ram_read_o  out  1  RAM read strobe
ram_write_o  out  1  RAM write strobe
ram_addr_o  out  ADDR_W  RAM address (registered)
ram_data_o  out  DATA_W  RAM write data (registered)
ram_byte_select_o  out  DATA_W/8  RAM byte mask (registered)
ram_ready_i  in  1  RAM completion, one cycle after strobe
ram_data_i  in  DATA_W  RAM read data
grant_o  out  1  currently/last granted port (0 = p0, 1 = p1)
busy_o  out  1  high in ISSUE and WAIT

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; ram_read_o, ram_write_o, p0/p1_ready_o, busy_o = 0; ram_addr_o, ram_data_o, ram_byte_select_o, grant_o = 0. Reset mid-transaction aborts it; any ram_ready_i arriving afterwards is ignored (no ready to either port).
- States: IDLE, ISSUE, WAIT.
- IDLE: port is requesting if read_i|write_i. No requester -> stay. Otherwise select a port (see arbitration), register its addr/data/byte_select into ram_* outputs, latch op (write if write_i, else read), set grant_o -> ISSUE.
- read_i and write_i both high on one port: treated as a write.
- ISSUE (exactly one cycle): ram_read_o or ram_write_o = 1 per latched op -> WAIT.
- WAIT: strobes 0. When ram_ready_i=1: granted port's ready_o = 1 combinationally in that cycle, its data_o = ram_data_i -> IDLE. ram_ready_i in IDLE/ISSUE is ignored.
- Latency: request seen in cycle N -> ram strobe in N+1 -> ready_o in N+2. Back-to-back throughput: one transaction per 3 cycles.
- p0_data_o and p1_data_o both carry ram_data_i at all times; consumers sample only on their ready_o. Writes also pulse ready_o.
- Requesters must drop or change the request the cycle after ready_o; a request still high in IDLE is a new transaction.
- Non-granted request is held pending, never dropped; it is granted at the next IDLE.
- Default arbitration (fixed priority): p1 wins when both request.

Optional Feature:
RAM_ARB_RR_EN: when defined, round-robin arbitration. On simultaneous requests, the port not equal to grant_o (last granted) wins. A single requester is always granted. After reset, grant_o=0, so p1 wins the first tie. When undefined, fixed priority is used (p1 > p0) and the round-robin logic is absent.

Decomposition:
- Shared package (ram_arb_pkg): state encoding constants (IDLE, ISSUE, WAIT), op encoding (OP_READ, OP_WRITE), port index constants (PORT_FETCH=0, PORT_LSU=1).
- One natural sub-module: ram_arb_select. This is a combinational 2-way priority/round-robin picker with inputs req[1:0] and last_grant, and output grant. The RAM_ARB_RR_EN switch lives only there.

Test Plan:
- Reset mid-WAIT: p0 read in flight, assert rst_i, then ram_ready_i=1 next cycle -> no p0_ready_o, state IDLE, all strobes 0.
- Single read: p0 read addr 0x0010 -> ram_read_o=1 with ram_addr_o=0x0010 at cycle+1; ram_ready_i at cycle+2 with ram_data_i=0xDEADBEEF -> p0_ready_o=1, p0_data_o=0xDEADBEEF; p1_ready_o stays 0.
- Byte write: p1 write addr 0x7FFF, data 0x12345678, mask 4'b0100 -> ram_write_o=1, ram_addr_o=0x7FFF, ram_byte_select_o=4'b0100; p1_ready_o pulses 2 cycles after request.
- Conflict, fixed priority: p0 and p1 both read, held -> p1 served first (ready at cycle 2), p0 served next (ready at cycle 5); grant_o sequence 1 then 0.
- Conflict, RAM_ARB_RR_EN: both ports hold requests continuously for 4 transactions -> grants alternate 1,0,1,0. Without the macro: p1 served for all 4 while p0 starves.
- Read+write both high on p0, addr 0x0003 -> ram_write_o=1, ram_read_o=0; late ram_ready_i in IDLE -> ignored, no ready pulse.
